spi_periph_bank: RTL and testbench
==================================

Name: spi_periph_bank

Overview:
- Peripheral bank behind the SPI register wrapper: a packet FIFO with programmable packet length, an 8-bit general-purpose output register and an 8-bit LED register.
- The wrapper decodes register address, read and write, then drives one enable strobe per peripheral together with write data, and muxes the read data back to the SPI slave.
- All strobes are single-cycle pulses in the clk domain.

Parameters:
- DW, 8, width of data, length, GPO and LED registers.
- DEPTH, 16, FIFO entries; power of 2, at most 2**DW.
- AW, $clog2(DEPTH), FIFO pointer width.

Ports:
- clk  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous active-low reset.
- fifo_input_en  in  1  push fifo_data_in.
- fifo_output_en  in  1  pop the head entry.
- fifo_data_in  in  DW  push data.
- fifo_data_out  out  DW  head entry (first-word fall-through).
- fifo_length_input_en  in  1  write the length register.
- fifo_length_output_en  in  1  length read strobe; no side effect.
- fifo_length_in  in  DW  packet length.
- fifo_length_out  out  DW  length register.
- fifo_full  out  1  packet fully loaded.
- fifo_read_complete  out  1  packet fully drained.
- gpo_wr_en  in  1  write the GPO register.
- gpo_rd_en  in  1  read strobe; no side effect.
- gpo_data_in  in  DW  GPO write data.
- gpo_data_out  out  DW  GPO register.
- gpo_pins  out  7  GPO register bits [6:0].
- led_wr_en  in  1  write the LED register.
- led_rd_en  in  1  read strobe; no side effect.
- led_data_in  in  DW  LED write data.
- led_data_out  out  DW  LED register.
- led0  out  1  LED register bit 0.
- led1  out  1  LED register bit 1.

Behaviour:
- Reset (async, active-low): all registers, pointers, counters and flags = 0. All outputs read 0.
- Storage: all storage is rising-edge clk; outputs are combinational from registers; write-to-readback latency is 1 cycle.
- GPO/LED write: on wr_en the register <= data_in. gpo_pins = reg[6:0]; led0 = reg[0], led1 = reg[1]. data_out is always the register value; rd_en is ignored apart from the port.
- FIFO state: mem[DEPTH], wr_ptr, rd_ptr, count (0..DEPTH), len register, rd_cnt.
- Length write: len <= fifo_length_in, rd_cnt <= 0, read_complete <= 0. Stored data is not flushed.
- Push (input_en, count < DEPTH): mem[wr_ptr] <= data_in, wr_ptr++ (wraps), count++, read_complete <= 0. A push at count == DEPTH is ignored.
- Pop (output_en, count > 0): rd_ptr++ (wraps), count--, rd_cnt++. A pop when empty is ignored and rd_cnt is unchanged.
- Simultaneous push and pop when non-empty: both take effect, count unchanged. When empty: only the push takes effect.
- fifo_data_out = mem[rd_ptr] when count > 0, else 0.
- fifo_full = (len != 0 && count >= len) || count == DEPTH. Level signal, not sticky.
- fifo_read_complete: set on the pop that makes rd_cnt == len with len != 0. Sticky until the next push or length write, then rd_cnt <= 0 on that same event.
- Length write with push or pop in the same cycle: the length write takes priority for rd_cnt and read_complete; data movement still occurs.
- len > DEPTH: full only at count == DEPTH.
- Reset asserted mid-operation clears everything immediately.

Decomposition:
- Package spi_periph_pkg: DW, DEPTH, and register address constants GPO = 7'h?, LED, FIFO = 7'h08, FIFO_LENGTH = 7'h09, shared with the wrapper.
- Sub-module pkt_fifo: FIFO plus length register.
- GPO and LED are trivial registers and stay inline in the top level.

Test Plan:
- Reset -> all outputs 0, fifo_full = 0, fifo_read_complete = 0.
- Length write 8'h03, then read length -> fifo_length_out = 8'h03, fifo_full = 0.
- Push 8'h01, 8'h02, 8'h03 -> fifo_full = 0 after two pushes, = 1 after the third; fifo_data_out = 8'h01.
- Three pops -> data_out sequence 8'h01, 8'h02, 8'h03. fifo_full drops after the first pop. fifo_read_complete = 1 after the third pop and stays set. A further pop leaves read_complete = 1 and data_out = 0.
- gpo_wr_en with 8'hA5 -> gpo_data_out = 8'hA5 and gpo_pins = 7'h25 next cycle. led_wr_en with 8'h02 -> led0 = 0, led1 = 1.
- Boundary cases:
  - Length 0 with DEPTH+1 pushes -> full only at DEPTH; extra push ignored.
  - Pointers wrap correctly.
  - Simultaneous push and pop keeps count.
  - Reset asserted mid-sequence clears all state.

Source files
------------

// File: rtl/spi_periph_pkg.sv
// Shared constants for the SPI peripheral bank and the register wrapper in front of it.
package spi_periph_pkg;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    // Register map as decoded by the SPI wrapper
    localparam logic [6:0] GPO         = 7'h01;
    localparam logic [6:0] LED         = 7'h02;
    localparam logic [6:0] FIFO        = 7'h08;
    localparam logic [6:0] FIFO_LENGTH = 7'h09;

endpackage

// File: rtl/spi_periph_bank_if.sv
// Strobe/data bundle between the SPI register wrapper (master) and the peripheral bank (slave).
interface spi_periph_bank_if;
    import spi_periph_pkg::*;

    logic          fifo_input_en;
    logic          fifo_output_en;
    logic [DW-1:0] fifo_data_in;
    logic [DW-1:0] fifo_data_out;
    logic          fifo_length_input_en;
    logic          fifo_length_output_en;
    logic [DW-1:0] fifo_length_in;
    logic [DW-1:0] fifo_length_out;
    logic          fifo_full;
    logic          fifo_read_complete;
    logic          gpo_wr_en;
    logic          gpo_rd_en;
    logic [DW-1:0] gpo_data_in;
    logic [DW-1:0] gpo_data_out;
    logic [6:0]    gpo_pins;
    logic          led_wr_en;
    logic          led_rd_en;
    logic [DW-1:0] led_data_in;
    logic [DW-1:0] led_data_out;
    logic          led0;
    logic          led1;

    modport master (
        output fifo_input_en, fifo_output_en, fifo_data_in,
        output fifo_length_input_en, fifo_length_output_en, fifo_length_in,
        output gpo_wr_en, gpo_rd_en, gpo_data_in,
        output led_wr_en, led_rd_en, led_data_in,
        input  fifo_data_out, fifo_length_out, fifo_full, fifo_read_complete,
        input  gpo_data_out, gpo_pins, led_data_out, led0, led1
    );

    modport slave (
        input  fifo_input_en, fifo_output_en, fifo_data_in,
        input  fifo_length_input_en, fifo_length_output_en, fifo_length_in,
        input  gpo_wr_en, gpo_rd_en, gpo_data_in,
        input  led_wr_en, led_rd_en, led_data_in,
        output fifo_data_out, fifo_length_out, fifo_full, fifo_read_complete,
        output gpo_data_out, gpo_pins, led_data_out, led0, led1
    );

endinterface

// File: rtl/pkt_fifo.sv
// Packet FIFO with a programmable packet length; flags a fully loaded and a fully drained packet.
module pkt_fifo
    import spi_periph_pkg::*;
(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          push_en,
    input  logic          pop_en,
    input  logic [DW-1:0] push_data,
    input  logic          len_we,
    input  logic [DW-1:0] len_in,
    output logic [DW-1:0] head_data,
    output logic [DW-1:0] len_out,
    output logic          full,
    output logic          read_complete
);

    localparam int unsigned CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [DW-1:0] len_q;
    logic [DW-1:0] rd_cnt;
    logic          rc_q;

    logic          push_ok;
    logic          pop_ok;
    logic          rc_clr;
    logic [DW-1:0] rd_cnt_nxt;

    // A push after a drained packet starts a new packet, so the drain count restarts
    always_comb begin
        push_ok    = push_en && (count < CW'(DEPTH));
        pop_ok     = pop_en && (count != '0);
        rc_clr     = push_ok && rc_q;
        rd_cnt_nxt = (rc_clr ? '0 : rd_cnt) + DW'(pop_ok);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Length write overrides push/pop effects on the drain tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q  <= '0;
            rd_cnt <= '0;
            rc_q   <= 1'b0;
        end else if (len_we) begin
            len_q  <= len_in;
            rd_cnt <= '0;
            rc_q   <= 1'b0;
        end else begin
            rd_cnt <= rd_cnt_nxt;
            if (pop_ok && (len_q != '0) && (rd_cnt_nxt == len_q)) rc_q <= 1'b1;
            else if (rc_clr)                                       rc_q <= 1'b0;
        end
    end

    assign head_data     = (count != '0) ? mem[rd_ptr] : '0;
    assign len_out       = len_q;
    assign full          = ((len_q != '0) && (32'(count) >= 32'(len_q))) || (count == CW'(DEPTH));
    assign read_complete = rc_q;

endmodule

// File: rtl/spi_periph_bank.sv
// Peripheral bank behind the SPI register wrapper: packet FIFO, GPO register and LED register.
module spi_periph_bank
    import spi_periph_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    spi_periph_bank_if.slave bus
);

    logic [DW-1:0] gpo_q;
    logic [DW-1:0] led_q;

    // Read strobes carry no side effect in this bank
    logic unused_rd;
    assign unused_rd = bus.fifo_length_output_en | bus.gpo_rd_en | bus.led_rd_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpo_q <= '0;
            led_q <= '0;
        end else begin
            if (bus.gpo_wr_en) gpo_q <= bus.gpo_data_in;
            if (bus.led_wr_en) led_q <= bus.led_data_in;
        end
    end

    assign bus.gpo_data_out = gpo_q;
    assign bus.gpo_pins     = gpo_q[6:0];
    assign bus.led_data_out = led_q;
    assign bus.led0         = led_q[0];
    assign bus.led1         = led_q[1];

    pkt_fifo u_pkt_fifo (
        .clk           (clk),
        .reset_n       (reset_n),
        .push_en       (bus.fifo_input_en),
        .pop_en        (bus.fifo_output_en),
        .push_data     (bus.fifo_data_in),
        .len_we        (bus.fifo_length_input_en),
        .len_in        (bus.fifo_length_in),
        .head_data     (bus.fifo_data_out),
        .len_out       (bus.fifo_length_out),
        .full          (bus.fifo_full),
        .read_complete (bus.fifo_read_complete)
    );

endmodule

// File: tb/tb_spi_periph_bank.sv
// Directed self-checking bench for spi_periph_bank.
module tb_spi_periph_bank;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    spi_periph_bank_if bus ();

    spi_periph_bank dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        bus.fifo_input_en         = 1'b0;
        bus.fifo_output_en        = 1'b0;
        bus.fifo_length_input_en  = 1'b0;
        bus.fifo_length_output_en = 1'b0;
        bus.gpo_wr_en             = 1'b0;
        bus.gpo_rd_en             = 1'b0;
        bus.led_wr_en             = 1'b0;
        bus.led_rd_en             = 1'b0;
    endtask

    task automatic push(input logic [7:0] d);
        bus.fifo_input_en = 1'b1;
        bus.fifo_data_in  = d;
        tick();
    endtask

    task automatic pop();
        bus.fifo_output_en = 1'b1;
        tick();
    endtask

    task automatic set_len(input logic [7:0] l);
        bus.fifo_length_input_en = 1'b1;
        bus.fifo_length_in       = l;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++; if (bus.fifo_data_out !== 8'h00) begin failures++; $display("FAIL rst_data got=%0h exp=00", bus.fifo_data_out); end
        checks++; if (bus.fifo_length_out !== 8'h00) begin failures++; $display("FAIL rst_len got=%0h exp=00", bus.fifo_length_out); end
        checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL rst_full got=%0b exp=0", bus.fifo_full); end
        checks++; if (bus.fifo_read_complete !== 1'b0) begin failures++; $display("FAIL rst_rc got=%0b exp=0", bus.fifo_read_complete); end
        checks++; if ({bus.gpo_data_out, bus.led_data_out, bus.gpo_pins, bus.led0, bus.led1} !== 25'h0) begin
            failures++; $display("FAIL rst_regs got gpo=%0h led=%0h exp=0", bus.gpo_data_out, bus.led_data_out); end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_length();
        set_len(8'h03);
        bus.fifo_length_output_en = 1'b1;
        tick();
        checks++; if (bus.fifo_length_out !== 8'h03) begin failures++; $display("FAIL len_rd got=%0h exp=03", bus.fifo_length_out); end
        checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL len_full got=%0b exp=0", bus.fifo_full); end
    endtask

    task automatic test_push();
        push(8'h01);
        push(8'h02);
        checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL push2_full got=%0b exp=0", bus.fifo_full); end
        push(8'h03);
        checks++; if (bus.fifo_full !== 1'b1) begin failures++; $display("FAIL push3_full got=%0b exp=1", bus.fifo_full); end
        checks++; if (bus.fifo_data_out !== 8'h01) begin failures++; $display("FAIL push_head got=%0h exp=01", bus.fifo_data_out); end
    endtask

    task automatic test_pop();
        pop();
        checks++; if (bus.fifo_data_out !== 8'h02) begin failures++; $display("FAIL pop1_data got=%0h exp=02", bus.fifo_data_out); end
        checks++; if (bus.fifo_full !== 1'b0) begin failures++; $display("FAIL pop1_full got=%0b exp=0", bus.fifo_full); end
        checks++; if (bus.fifo_read_complete !== 1'b0) begin failures++; $display("FAIL pop1_rc got=%0b exp=0", bus.fifo_read_complete); end
        pop();
        checks++; if (bus.fifo_data_out !== 8'h03) begin failures++; $display("FAIL pop2_data got=%0h exp=03", bus.fifo_data_out); end
        checks++; if (bus.fifo_read_complete !== 1'b0) begin failures++; $display("FAIL pop2_rc got=%0b exp=0", bus.fifo_read_complete); end
        pop();
        checks++; if (bus.fifo_read_complete !== 1'b1) begin failures++; $display("FAIL pop3_rc got=%0b exp=1", bus.fifo_read_complete); end
        checks++; if (bus.fifo_data_out !== 8'h00) begin failures++; $display("FAIL pop3_data got=%0h exp=00", bus.fifo_data_out); end
        pop();
        checks++; if (bus.fifo_read_complete !== 1'b1) begin failures++; $display("FAIL pop4_rc got=%0b exp=1", bus.fifo_read_complete); end
        checks++; if (bus.fifo_data_out !== 8'h00) begin failures++; $display("FAIL pop4_data got=%0h exp=00", bus.fifo_data_out); end
        push(8'h44);
        checks++; if (bus.fifo_read_complete !== 1'b0) begin failures++; $display("FAIL push_clr_rc got=%0b exp=0", bus.fifo_read_complete); end
        checks++; if (bus.fifo_data_out !== 8'h44) begin failures++; $display("FAIL push_clr_data got=%0h exp=44", bus.fifo_data_out); end
        pop();
        checks++; if (bus.fifo_read_complete !== 1'b0) begin failures++; $display("FAIL repop_rc got=%0b exp=0", bus.fifo_read_complete); end
    endtask

    task automatic test_gpo_led();
        bus.gpo_wr_en   = 1'b1;
        bus.gpo_data_in = 8'hA5;
        tick();
        checks++; if (bus.gpo_data_out !== 8'hA5) begin failures++; $display("FAIL gpo_data got=%0h exp=a5", bus.gpo_data_out); end
        checks++; if (bus.gpo_pins !== 7'h25) begin failures++; $display("FAIL gpo_pins got=%0h exp=25", bus.gpo_pins); end
        bus.led_wr_en   = 1'b1;
        bus.led_data_in = 8'h02;
        bus.gpo_rd_en   = 1'b1;
        bus.gpo_data_in = 8'h3C;
        tick();
        checks++; if ({bus.led1, bus.led0} !== 2'b10) begin failures++; $display("FAIL led_bits got=%0b%0b exp=10", bus.led1, bus.led0); end
        checks++; if (bus.led_data_out !== 8'h02) begin failures++; $display("FAIL led_data got=%0h exp=02", bus.led_data_out); end
        checks++; if (bus.gpo_data_out !== 8'hA5) begin failures++; $display("FAIL gpo_rd_noeff got=%0h exp=a5", bus.gpo_data_out); end
    endtask

    task automatic test_len0_overflow();
        set_len(8'h00);
        for (int k = 1; k <= 17; k++) begin
            push(8'(8'h0F + k));
            checks++;
            if (bus.fifo_full !== (k >= 16)) begin
                failures++; $display("FAIL ovf_full k=%0d got=%0b exp=%0b", k, bus.fifo_full, (k >= 16)); end
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (bus.fifo_data_out !== 8'(8'h10 + k)) begin
                failures++; $display("FAIL wrap_data k=%0d got=%0h exp=%0h", k, bus.fifo_data_out, 8'(8'h10 + k)); end
            pop();
        end
        checks++; if (bus.fifo_data_out !== 8'h00) begin failures++; $display("FAIL wrap_empty got=%0h exp=00", bus.fifo_data_out); end
        checks++; if (bus.fifo_read_complete !== 1'b0) begin failures++; $display("FAIL len0_rc got=%0b exp=0", bus.fifo_read_complete); end
    endtask

    task automatic test_back_to_back();
        push(8'hA1);
        push(8'hB2);
        bus.fifo_input_en  = 1'b1;
        bus.fifo_output_en = 1'b1;
        bus.fifo_data_in   = 8'hC3;
        tick();
        checks++; if (bus.fifo_data_out !== 8'hB2) begin failures++; $display("FAIL simul_head got=%0h exp=b2", bus.fifo_data_out); end
        pop();
        checks++; if (bus.fifo_data_out !== 8'hC3) begin failures++; $display("FAIL simul_next got=%0h exp=c3", bus.fifo_data_out); end
        pop();
        checks++; if (bus.fifo_data_out !== 8'h00) begin failures++; $display("FAIL simul_empty got=%0h exp=00", bus.fifo_data_out); end
        bus.fifo_input_en  = 1'b1;
        bus.fifo_output_en = 1'b1;
        bus.fifo_data_in   = 8'hD4;
        tick();
        checks++; if (bus.fifo_data_out !== 8'hD4) begin failures++; $display("FAIL simul_empty_push got=%0h exp=d4", bus.fifo_data_out); end
        pop();
        checks++; if (bus.fifo_data_out !== 8'h00) begin failures++; $display("FAIL simul_drain got=%0h exp=00", bus.fifo_data_out); end
    endtask

    task automatic test_reset_mid();
        set_len(8'h02);
        push(8'h55);
        push(8'h66);
        bus.gpo_wr_en   = 1'b1;
        bus.gpo_data_in = 8'hFF;
        bus.led_wr_en   = 1'b1;
        bus.led_data_in = 8'hFF;
        tick();
        checks++; if (bus.fifo_full !== 1'b1) begin failures++; $display("FAIL mid_pre_full got=%0b exp=1", bus.fifo_full); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({bus.fifo_data_out, bus.fifo_length_out, bus.fifo_full, bus.fifo_read_complete} !== 18'h0) begin
            failures++; $display("FAIL mid_fifo got data=%0h len=%0h full=%0b", bus.fifo_data_out, bus.fifo_length_out, bus.fifo_full); end
        checks++; if ({bus.gpo_data_out, bus.led_data_out, bus.gpo_pins, bus.led0, bus.led1} !== 25'h0) begin
            failures++; $display("FAIL mid_regs got gpo=%0h led=%0h exp=0", bus.gpo_data_out, bus.led_data_out); end
        @(negedge clk);
        reset_n = 1'b1;
        push(8'h77);
        checks++; if (bus.fifo_data_out !== 8'h77) begin failures++; $display("FAIL post_rst_head got=%0h exp=77", bus.fifo_data_out); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        bus.fifo_input_en         = 1'b0;
        bus.fifo_output_en        = 1'b0;
        bus.fifo_data_in          = '0;
        bus.fifo_length_input_en  = 1'b0;
        bus.fifo_length_output_en = 1'b0;
        bus.fifo_length_in        = '0;
        bus.gpo_wr_en             = 1'b0;
        bus.gpo_rd_en             = 1'b0;
        bus.gpo_data_in           = '0;
        bus.led_wr_en             = 1'b0;
        bus.led_rd_en             = 1'b0;
        bus.led_data_in           = '0;
        test_reset();
        test_length();
        test_push();
        test_pop();
        test_gpo_led();
        test_len0_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
